// File: rtl/global_buffer_pkg.sv
// global_buffer_pkg: shared GLB constants and kick scheduler types.
package global_buffer_pkg;
    localparam int NUM_GLB_TILES = 16;
    typedef enum logic {KICK_STRM = 1'b0, KICK_PC = 1'b1} kick_type_e;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_GAP = 2'd2, ST_WAIT = 2'd3} kick_state_e;
endpackage

// File: rtl/glb_kick_scheduler_if.sv
// glb_kick_scheduler_if: host kick handshake plus per-tile start/interrupt lines.
interface glb_kick_scheduler_if #(
    parameter int NUM_GLB_TILES = global_buffer_pkg::NUM_GLB_TILES,
    parameter int GAP_WIDTH     = 4,
    parameter int TIMEOUT_WIDTH = 16
);
    logic                     kick_valid;
    logic                     kick_ready;
    logic [NUM_GLB_TILES-1:0] kick_mask;
    logic                     kick_type;
    logic [GAP_WIDTH-1:0]     cfg_gap;
    logic [1:0]               cfg_strm_done_sel;
    logic [TIMEOUT_WIDTH-1:0] cfg_timeout;
    logic                     abort;
    logic [NUM_GLB_TILES-1:0] strm_start_pulse;
    logic [NUM_GLB_TILES-1:0] pc_start_pulse;
    logic [NUM_GLB_TILES-1:0] strm_g2f_interrupt_pulse;
    logic [NUM_GLB_TILES-1:0] strm_f2g_interrupt_pulse;
    logic [NUM_GLB_TILES-1:0] pcfg_g2f_interrupt_pulse;
    logic [NUM_GLB_TILES-1:0] pending_mask;
    logic                     busy;
    logic                     done_pulse;
    logic                     timeout_pulse;
    logic                     spurious_err;

    modport slave (
        input  kick_valid, kick_mask, kick_type, cfg_gap, cfg_strm_done_sel, cfg_timeout, abort,
               strm_g2f_interrupt_pulse, strm_f2g_interrupt_pulse, pcfg_g2f_interrupt_pulse,
        output kick_ready, strm_start_pulse, pc_start_pulse, pending_mask, busy, done_pulse,
               timeout_pulse, spurious_err
    );

    modport master (
        output kick_valid, kick_mask, kick_type, cfg_gap, cfg_strm_done_sel, cfg_timeout, abort,
               strm_g2f_interrupt_pulse, strm_f2g_interrupt_pulse, pcfg_g2f_interrupt_pulse,
        input  kick_ready, strm_start_pulse, pc_start_pulse, pending_mask, busy, done_pulse,
               timeout_pulse, spurious_err
    );
endinterface

// File: rtl/glb_kick_prio_enc.sv
// glb_kick_prio_enc: lowest-set-bit priority encoder with one-hot output.
module glb_kick_prio_enc #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] onehot,
    output logic             valid
);
    assign onehot = req & (~req + 1'b1);
    assign valid  = |req;
endmodule

// File: rtl/glb_kick_scheduler.sv
// glb_kick_scheduler: staggers per-tile start pulses for a kick and aggregates
// the tiles' completion interrupts into one done or timeout pulse.
module glb_kick_scheduler #(
    parameter int NUM_GLB_TILES = global_buffer_pkg::NUM_GLB_TILES,
    parameter int GAP_WIDTH     = 4,
    parameter int TIMEOUT_WIDTH = 16
) (
    input logic clk,
    input logic reset_n,
    glb_kick_scheduler_if.slave bus
);
    import global_buffer_pkg::*;

    localparam int N = NUM_GLB_TILES;
    localparam logic [1:0] IDLE  = 2'(ST_IDLE);
    localparam logic [1:0] ISSUE = 2'(ST_ISSUE);
    localparam logic [1:0] GAP   = 2'(ST_GAP);
    localparam logic [1:0] WAIT  = 2'(ST_WAIT);

    logic [1:0]               state, state_nx, sel;
    kick_type_e               ktype;
    logic [N-1:0]             issue_mask, pending, seen_g2f, seen_f2g;
    logic [N-1:0]             pick, issue, ng, nf, complete, pend_nx, irq_any;
    logic [GAP_WIDTH-1:0]     gap_cnt;
    logic [TIMEOUT_WIDTH-1:0] to_cnt, to_nx;
    logic                     pick_valid, active, accept, timeout_hit;

    glb_kick_prio_enc #(.WIDTH(N)) u_enc (.req(issue_mask), .onehot(pick), .valid(pick_valid));

    assign bus.kick_ready   = state == IDLE;
    assign bus.pending_mask = pending;
    assign active  = state != IDLE;
    assign accept  = state == IDLE && bus.kick_valid && !bus.abort;
    assign issue   = state == ISSUE && pick_valid && !bus.abort ? pick : '0;
    assign irq_any = bus.strm_g2f_interrupt_pulse | bus.strm_f2g_interrupt_pulse | bus.pcfg_g2f_interrupt_pulse;
    // Only irqs from tiles pending before this cycle count; same-cycle starts do not.
    assign ng = seen_g2f | (bus.strm_g2f_interrupt_pulse & pending);
    assign nf = seen_f2g | (bus.strm_f2g_interrupt_pulse & pending);
    assign complete = !active ? '0
                    : ktype == KICK_PC ? pending & bus.pcfg_g2f_interrupt_pulse
                    : pending & (sel[0] ? ng : '1) & (sel[1] ? nf : '1);
    assign pend_nx = (pending & ~complete) | issue;
    assign to_nx = |complete ? '0 : &to_cnt ? to_cnt : to_cnt + 1'b1;
    assign timeout_hit = bus.cfg_timeout != '0 && to_nx == bus.cfg_timeout;

    always_comb begin
        state_nx = state;
        if (bus.abort) state_nx = IDLE;
        else if (state == IDLE) state_nx = !bus.kick_valid ? IDLE : bus.kick_mask == '0 ? WAIT : ISSUE;
        else if (state == ISSUE) state_nx = (issue_mask & ~pick) == '0 ? WAIT : bus.cfg_gap == '0 ? ISSUE : GAP;
        else if (state == GAP) state_nx = gap_cnt == GAP_WIDTH'(1) ? ISSUE : GAP;
        else state_nx = pend_nx == '0 || timeout_hit ? IDLE : WAIT;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                <= IDLE;
            ktype                <= KICK_STRM;
            sel                  <= '0;
            issue_mask           <= '0;
            pending              <= '0;
            seen_g2f             <= '0;
            seen_f2g             <= '0;
            gap_cnt              <= '0;
            to_cnt               <= '0;
            bus.strm_start_pulse <= '0;
            bus.pc_start_pulse   <= '0;
            bus.busy             <= 1'b0;
            bus.done_pulse       <= 1'b0;
            bus.timeout_pulse    <= 1'b0;
            bus.spurious_err     <= 1'b0;
        end else begin
            state                <= state_nx;
            bus.busy             <= state_nx != IDLE;
            bus.strm_start_pulse <= ktype == KICK_STRM ? issue : '0;
            bus.pc_start_pulse   <= ktype == KICK_PC ? issue : '0;
            bus.done_pulse       <= !bus.abort && state == WAIT && pend_nx == '0;
            bus.timeout_pulse    <= !bus.abort && state == WAIT && pend_nx != '0 && timeout_hit;
            bus.spurious_err     <= (bus.spurious_err && !accept) || |(irq_any & ~pending);
            if (bus.abort) begin
                issue_mask <= '0;
                pending    <= '0;
                seen_g2f   <= '0;
                seen_f2g   <= '0;
            end else if (accept) begin
                ktype      <= kick_type_e'(bus.kick_type);
                sel        <= !bus.kick_type && bus.cfg_strm_done_sel == 2'b00 ? 2'b01 : bus.cfg_strm_done_sel;
                issue_mask <= bus.kick_mask;
                pending    <= '0;
                seen_g2f   <= '0;
                seen_f2g   <= '0;
                to_cnt     <= '0;
            end else if (active) begin
                issue_mask <= issue_mask & ~issue;
                pending    <= pend_nx;
                seen_g2f   <= ng & ~complete;
                seen_f2g   <= nf & ~complete;
                gap_cnt    <= state == ISSUE ? bus.cfg_gap : state == GAP ? gap_cnt - 1'b1 : gap_cnt;
                to_cnt     <= state == WAIT ? to_nx : |complete ? '0 : to_cnt;
            end
        end
    end
endmodule

// File: tb/tb_glb_kick_scheduler.sv
// tb_glb_kick_scheduler: directed scenarios plus random traffic, checked every
// cycle against a queue-based behavioural model of the kick scheduler.
module tb_glb_kick_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   cmp_en = 1'b0;

    always #5 clk = ~clk;

    glb_kick_scheduler_if #(.NUM_GLB_TILES(16), .GAP_WIDTH(4), .TIMEOUT_WIDTH(16)) ifc ();

    glb_kick_scheduler #(.NUM_GLB_TILES(16), .GAP_WIDTH(4), .TIMEOUT_WIDTH(16)) dut (
        .clk(clk),
        .reset_n(rst_n),
        .bus(ifc)
    );

    // Model: tiles still to start sit in a queue; gap_left counts idle cycles before the next start.
    bit        m_busy, m_pc, e_done, e_to, e_spur;
    bit [1:0]  m_sel;
    bit [15:0] m_pend, m_g, m_f, e_strm, e_pc;
    int        q[$];
    int        gap_left, m_wait;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_pc = 0; m_sel = 0; m_pend = 0; m_g = 0; m_f = 0;
        e_strm = 0; e_pc = 0; e_done = 0; e_to = 0; e_spur = 0;
        q.delete(); gap_left = 0; m_wait = 0;
    endtask

    task automatic model_step();
        bit [15:0] g2f, f2g, pci, old;
        bit any_done;
        int t;
        g2f = ifc.strm_g2f_interrupt_pulse;
        f2g = ifc.strm_f2g_interrupt_pulse;
        pci = ifc.pcfg_g2f_interrupt_pulse;
        old = m_pend;
        e_strm = 0; e_pc = 0; e_done = 0; e_to = 0;
        if (ifc.abort) begin
            m_busy = 0; q.delete(); m_pend = 0; m_g = 0; m_f = 0;
            e_spur |= |((g2f | f2g | pci) & ~old);
            return;
        end
        if (!m_busy) begin
            if (ifc.kick_valid) begin
                e_spur = 0;
                m_busy = 1; q.delete();
                for (int i = 0; i < 16; i++) if (ifc.kick_mask[i]) q.push_back(i);
                m_pc = ifc.kick_type;
                m_sel = (!m_pc && ifc.cfg_strm_done_sel == 0) ? 2'b01 : ifc.cfg_strm_done_sel;
                m_pend = 0; m_g = 0; m_f = 0; m_wait = 0; gap_left = 0;
            end
            e_spur |= |((g2f | f2g | pci) & ~old);
            return;
        end
        e_spur |= |((g2f | f2g | pci) & ~old);
        any_done = 0;
        for (int i = 0; i < 16; i++) begin
            if (old[i]) begin
                if (m_pc) begin
                    if (pci[i]) begin m_pend[i] = 0; any_done = 1; end
                end else begin
                    m_g[i] |= g2f[i];
                    m_f[i] |= f2g[i];
                    if ((!m_sel[0] || m_g[i]) && (!m_sel[1] || m_f[i])) begin
                        m_pend[i] = 0; m_g[i] = 0; m_f[i] = 0; any_done = 1;
                    end
                end
            end
        end
        if (any_done) m_wait = 0;
        if (q.size() != 0) begin
            if (gap_left > 0) gap_left--;
            else begin
                t = q.pop_front();
                m_pend[t] = 1;
                if (m_pc) e_pc[t] = 1; else e_strm[t] = 1;
                if (q.size() != 0) gap_left = int'(ifc.cfg_gap);
            end
        end else if (m_pend == 0) begin
            e_done = 1; m_busy = 0;
        end else begin
            if (!any_done && m_wait < 65535) m_wait++;
            if (ifc.cfg_timeout != 0 && m_wait == int'(ifc.cfg_timeout)) begin e_to = 1; m_busy = 0; end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else model_step();
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            chk("strm_start", ifc.strm_start_pulse, e_strm);
            chk("pc_start", ifc.pc_start_pulse, e_pc);
            chk("pending", ifc.pending_mask, m_pend);
            chk("busy", ifc.busy, m_busy);
            chk("kick_ready", ifc.kick_ready, !m_busy);
            chk("done", ifc.done_pulse, e_done);
            chk("timeout", ifc.timeout_pulse, e_to);
            chk("spurious", ifc.spurious_err, e_spur);
        end
    end

    task automatic idle_in();
        ifc.kick_valid = 0; ifc.abort = 0;
        ifc.strm_g2f_interrupt_pulse = 0; ifc.strm_f2g_interrupt_pulse = 0; ifc.pcfg_g2f_interrupt_pulse = 0;
    endtask

    task automatic kick(input logic [15:0] mask, input logic ty, input logic [3:0] gap,
                        input logic [1:0] sel, input logic [15:0] to);
        ifc.kick_valid = 1; ifc.kick_mask = mask; ifc.kick_type = ty;
        ifc.cfg_gap = gap; ifc.cfg_strm_done_sel = sel; ifc.cfg_timeout = to;
        @(negedge clk);
        ifc.kick_valid = 0;
    endtask

    initial begin
        idle_in();
        ifc.kick_mask = 0; ifc.kick_type = 0; ifc.cfg_gap = 0; ifc.cfg_strm_done_sel = 0; ifc.cfg_timeout = 0;
        repeat (3) @(negedge clk);
        chk("rst ready", ifc.kick_ready, 1);
        chk("rst busy", ifc.busy, 0);
        chk("rst pending", ifc.pending_mask, 0);
        chk("rst spurious", ifc.spurious_err, 0);
        chk("rst pulses", {ifc.strm_start_pulse, ifc.pc_start_pulse}, 0);
        rst_n = 1; cmp_en = 1;
        @(negedge clk);

        // Stream kick, two tiles, gap of two idle cycles.
        kick(16'h0005, 0, 2, 2'b01, 0);
        @(negedge clk); chk("t1 first", ifc.strm_start_pulse, 16'h0001);
        @(negedge clk); chk("t1 gap a", ifc.strm_start_pulse, 0);
        @(negedge clk); chk("t1 gap b", ifc.strm_start_pulse, 0);
        @(negedge clk); chk("t1 second", ifc.strm_start_pulse, 16'h0004);
        chk("t1 pend", ifc.pending_mask, 16'h0005);
        ifc.strm_g2f_interrupt_pulse = 16'h0001;
        @(negedge clk); ifc.strm_g2f_interrupt_pulse = 16'h0004;
        chk("t1 pend2", ifc.pending_mask, 16'h0004); chk("t1 nodone", ifc.done_pulse, 0);
        @(negedge clk); idle_in();
        chk("t1 done", ifc.done_pulse, 1); chk("t1 pend0", ifc.pending_mask, 0);
        @(negedge clk); chk("t1 done once", ifc.done_pulse, 0);

        // PC kick on all tiles, back to back.
        kick(16'hFFFF, 1, 0, 2'b00, 0);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk); chk("t2 pc seq", ifc.pc_start_pulse, 32'h1 << k);
        end
        chk("t2 pend", ifc.pending_mask, 16'hFFFF);
        ifc.pcfg_g2f_interrupt_pulse = 16'hFFFF;
        @(negedge clk); idle_in();
        chk("t2 done", ifc.done_pulse, 1); chk("t2 pend0", ifc.pending_mask, 0);

        // Stream kick needing both irqs.
        kick(16'h0028, 0, 0, 2'b11, 0);
        @(negedge clk);
        @(negedge clk); chk("t3 pend", ifc.pending_mask, 16'h0028);
        ifc.strm_g2f_interrupt_pulse = 16'h0008;
        @(negedge clk); idle_in();
        chk("t3 half", ifc.pending_mask, 16'h0028); chk("t3 nodone", ifc.done_pulse, 0);
        ifc.strm_f2g_interrupt_pulse = 16'h0008;
        @(negedge clk); idle_in();
        chk("t3 tile3", ifc.pending_mask, 16'h0020);
        ifc.strm_g2f_interrupt_pulse = 16'h0020; ifc.strm_f2g_interrupt_pulse = 16'h0020;
        @(negedge clk); idle_in();
        chk("t3 done", ifc.done_pulse, 1); chk("t3 pend0", ifc.pending_mask, 0);

        // Watchdog: tile 0 never answers.
        kick(16'h0001, 0, 0, 2'b01, 16'd10);
        repeat (10) @(negedge clk);
        chk("t4 early", ifc.timeout_pulse, 0);
        @(negedge clk);
        chk("t4 timeout", ifc.timeout_pulse, 1); chk("t4 nodone", ifc.done_pulse, 0);
        chk("t4 stale", ifc.pending_mask, 16'h0001); chk("t4 ready", ifc.kick_ready, 1);
        ifc.cfg_timeout = 0;

        // Spurious irq in IDLE, then an empty kick.
        @(negedge clk); ifc.strm_g2f_interrupt_pulse = 16'h0080;
        @(negedge clk); idle_in(); chk("t5 spur", ifc.spurious_err, 1);
        @(negedge clk); chk("t5 sticky", ifc.spurious_err, 1);
        kick(16'h0000, 0, 0, 2'b01, 0);
        chk("t5 cleared", ifc.spurious_err, 0); chk("t5 nostart", ifc.strm_start_pulse, 0);
        @(negedge clk); chk("t5 done", ifc.done_pulse, 1); chk("t5 nostart2", ifc.strm_start_pulse, 0);

        // Abort during GAP.
        @(negedge clk);
        kick(16'h00F0, 0, 3, 2'b01, 0);
        @(negedge clk); chk("t6 tile4", ifc.strm_start_pulse, 16'h0010);
        ifc.abort = 1;
        @(negedge clk); ifc.abort = 0;
        chk("t6 ready", ifc.kick_ready, 1); chk("t6 pend0", ifc.pending_mask, 0);
        repeat (6) begin
            @(negedge clk);
            chk("t6 quiet", {ifc.strm_start_pulse, ifc.done_pulse, ifc.timeout_pulse}, 0);
        end

        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            ifc.kick_valid = $urandom_range(0, 3) == 0;
            ifc.kick_mask = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom & $urandom);
            ifc.kick_type = 1'($urandom_range(0, 1));
            ifc.cfg_gap = 4'($urandom_range(0, 3));
            ifc.cfg_strm_done_sel = 2'($urandom_range(0, 3));
            ifc.cfg_timeout = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 25));
            ifc.strm_g2f_interrupt_pulse = ($urandom_range(0, 2) == 0) ? m_pend & 16'($urandom) : 16'h0;
            ifc.strm_f2g_interrupt_pulse = ($urandom_range(0, 2) == 0) ? m_pend & 16'($urandom) : 16'h0;
            ifc.pcfg_g2f_interrupt_pulse = ($urandom_range(0, 2) == 0) ? m_pend & 16'($urandom) : 16'h0;
            if ($urandom_range(0, 49) == 0) ifc.strm_g2f_interrupt_pulse[$urandom_range(0, 15)] = 1'b1;
            ifc.abort = $urandom_range(0, 299) == 0;
        end

        // Reset in the middle of a kick.
        @(negedge clk); idle_in(); ifc.cfg_timeout = 0;
        repeat (40) @(negedge clk);
        kick(16'hFFFF, 0, 1, 2'b01, 0);
        @(negedge clk);
        #2 rst_n = 0;
        @(negedge clk);
        chk("mid rst busy", ifc.busy, 0); chk("mid rst pend", ifc.pending_mask, 0);
        chk("mid rst ready", ifc.kick_ready, 1);
        rst_n = 1;
        repeat (4) begin
            @(negedge clk);
            chk("post rst quiet", {ifc.strm_start_pulse, ifc.pc_start_pulse, ifc.done_pulse, ifc.timeout_pulse}, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
